// File: rtl/sync_seeker_array.sv
// Header-alignment seeker: NUM_SEEKERS parallel HUNT/LOCKED seekers, each scanning its own
// slice of candidate offsets, with a sticky arbiter that reports one locked offset.
module sync_seeker_array #(
  parameter int FRAME_W     = 66,
  parameter int NUM_SEEKERS = 4,
  parameter int LOCK_CNT    = 32,
  parameter int ERR_WIN     = 64,
  parameter int ERR_MAX     = 16,
  parameter int POS_W       = $clog2(FRAME_W),
  parameter int SEL_W       = (NUM_SEEKERS > 1) ? $clog2(NUM_SEEKERS) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [FRAME_W:0]   gbox_buffer,
  input  logic               buffer_dv,
  output logic               is_synced,
  output logic [POS_W-1:0]   offset_pos,
  output logic [SEL_W-1:0]   winner_o,
  output logic               sync_lost
);

  localparam int RANGE  = (FRAME_W + NUM_SEEKERS - 1) / NUM_SEEKERS;
  localparam int SLOTS  = 2 ** SEL_W;
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W  = $clog2(ERR_WIN + 1);

  typedef enum logic {HUNT, LOCKED} seek_state_t;

  // Padded to a power of two so winner_o can index without range checks.
  logic [SLOTS-1:0] locked;
  logic [POS_W-1:0] cands [SLOTS];

  for (genvar k = 0; k < SLOTS; k++) begin : g_seek
    localparam int LO     = k * RANGE;
    localparam int HI_RAW = (k + 1) * RANGE - 1;
    localparam int HI     = (HI_RAW < FRAME_W - 1) ? HI_RAW : FRAME_W - 1;

    if (k < NUM_SEEKERS && LO < FRAME_W) begin : g_live
      seek_state_t       state_q, state_d;
      logic [POS_W-1:0]  cand_q, cand_d, cand_adv;
      logic [GOOD_W-1:0] good_q, good_d;
      logic [WIN_W-1:0]  win_q, win_d, err_q, err_d, win_inc, err_inc;
      logic [1:0]        pair;
      logic              hdr_ok;

      assign pair     = 2'(gbox_buffer >> cand_q);
      assign hdr_ok   = pair[1] ^ pair[0];
      assign cand_adv = (cand_q == POS_W'(HI)) ? POS_W'(LO) : cand_q + 1'b1;

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          state_q <= HUNT;
          cand_q  <= POS_W'(LO);
          good_q  <= '0;
          win_q   <= '0;
          err_q   <= '0;
        end else begin
          state_q <= state_d;
          cand_q  <= cand_d;
          good_q  <= good_d;
          win_q   <= win_d;
          err_q   <= err_d;
        end
      end

      always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        good_d  = good_q;
        win_d   = win_q;
        err_d   = err_q;
        win_inc = win_q + 1'b1;
        err_inc = err_q + WIN_W'(!hdr_ok);
        if (buffer_dv) begin
          case (state_q)
            HUNT: begin
              if (hdr_ok) begin
                good_d = good_q + 1'b1;
                if (good_d == GOOD_W'(LOCK_CNT)) begin
                  state_d = LOCKED;
                  win_d   = '0;
                  err_d   = '0;
                end
              end else begin
                good_d = '0;
                cand_d = cand_adv;
              end
            end
            LOCKED: begin
              win_d = win_inc;
              err_d = err_inc;
              // Too many errors beats a window rollover on the same beat.
              if (err_inc == WIN_W'(ERR_MAX)) begin
                state_d = HUNT;
                cand_d  = cand_adv;
                good_d  = '0;
                win_d   = '0;
                err_d   = '0;
              end else if (win_inc == WIN_W'(ERR_WIN)) begin
                win_d = '0;
                err_d = '0;
              end
            end
            default: ;
          endcase
        end
      end

      assign locked[k] = (state_q == LOCKED);
      assign cands[k]  = cand_q;
    end else begin : g_tie
      assign locked[k] = 1'b0;
      assign cands[k]  = '0;
    end
  end

  logic             found;
  logic [SEL_W-1:0] pick;

  // Keep a still-locked winner; otherwise the lowest locked index takes over.
  always_comb begin
    found = 1'b0;
    pick  = winner_o;
    if (is_synced && locked[winner_o]) begin
      found = 1'b1;
    end else begin
      for (int i = SLOTS - 1; i >= 0; i--) begin
        if (locked[i]) begin
          found = 1'b1;
          pick  = SEL_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      is_synced  <= 1'b0;
      sync_lost  <= 1'b0;
      winner_o   <= '0;
      offset_pos <= '0;
    end else begin
      is_synced <= found;
      sync_lost <= is_synced & ~found;
      if (found) begin
        winner_o   <= pick;
        offset_pos <= cands[pick];
      end
    end
  end

endmodule
